// File: rtl/gf_pkg.sv
// gf_pkg: shared definitions for the iterative GF(2^M) multiplier.
//   - GF_M_DEFAULT / GF_POLY_DEFAULT : default field width and primitive polynomial
//   - gf_state_t                     : controller state encoding (IDLE/BUSY/DONE)
//   - xtime()                        : multiply-by-x with reduction, width-generic
package gf_pkg;

    localparam int          GF_M_DEFAULT    = 4;
    localparam logic [16:0] GF_POLY_DEFAULT = 17'h13;   // x^4 + x + 1

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } gf_state_t;

    // Multiply r by x in GF(2^m). r is zero-extended to 16 bits; poly holds the
    // low m coefficients of the primitive polynomial (the x^m term is implicit).
    function automatic logic [15:0] xtime(input logic [15:0] r,
                                          input logic [15:0] poly,
                                          input int          m);
        logic [15:0] mask;
        logic [15:0] s;
        mask = 16'((17'h1 << m) - 17'h1);
        s    = (r << 1) & mask;
        if (r[4'(m - 1)]) begin
            s = s ^ (poly & mask);
        end
        return s;
    endfunction

endpackage

// File: rtl/gf_mult_seq_if.sv
// gf_mult_seq_if: operand/result handshake bundle for gf_mult_seq.
//   in_valid/in_ready/in_a/in_b/in_acc : operand channel (producer -> multiplier)
//   out_valid/out_ready/out_c          : result channel (multiplier -> consumer)
// Handshake rule on both channels: a transfer happens on a rising clock edge
// where valid && ready are both 1; the sender holds valid and data stable until
// that edge, and valid never depends combinationally on ready.
interface gf_mult_seq_if #(
    parameter int M = gf_pkg::GF_M_DEFAULT
) ();
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] in_a;
    logic [M-1:0] in_b;
    logic         in_acc;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out_c;

    modport master (
        output in_valid, in_a, in_b, in_acc, out_ready,
        input  in_ready, out_valid, out_c
    );

    modport slave (
        input  in_valid, in_a, in_b, in_acc, out_ready,
        output in_ready, out_valid, out_c
    );
endinterface

// File: rtl/gf_mult_step.sv
// gf_mult_step: one combinational MSB-first Horner step of a GF(2^M) product.
//   r      in  M  partial product so far
//   a      in  M  multiplicand
//   b_bit  in  1  current multiplier bit
//   r_next out M  xtime(r) ^ (b_bit ? a : 0)
module gf_mult_step
    import gf_pkg::*;
#(
    parameter int          M    = GF_M_DEFAULT,
    parameter logic [16:0] POLY = GF_POLY_DEFAULT
) (
    input  logic [M-1:0] r,
    input  logic [M-1:0] a,
    input  logic         b_bit,
    output logic [M-1:0] r_next
);
    always_comb begin
        r_next = M'(xtime(16'(r), POLY[15:0], M)) ^ (b_bit ? a : '0);
    end
endmodule

// File: rtl/gf_mult_seq.sv
// gf_mult_seq: iterative GF(2^M) multiplier, one product bit per cycle.
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   bus        slave modport of gf_mult_seq_if (operand and result channels)
//   state_dbg  out  current controller state
// Optional feature macro: GF_MULT_ACC_EN adds an accumulator so that in_acc=1
// at accept XORs the product with the last delivered result.
// Latency: accept on edge E0, out_valid on edge E0+M; M+1 cycles per result
// when back-to-back.
module gf_mult_seq
    import gf_pkg::*;
#(
    parameter int          M    = GF_M_DEFAULT,
    parameter logic [16:0] POLY = GF_POLY_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    gf_mult_seq_if.slave  bus,
    output gf_state_t     state_dbg
);
    if ((M < 2) || (M > 16) || (((POLY >> M) & 17'h1) == 17'h0)) begin : g_bad_param
        $error("gf_mult_seq: M must be 2..16 and POLY[M] must be 1");
    end

    gf_state_t    state, state_nxt;
    logic [3:0]   cnt;
    logic [M-1:0] a_q;
    logic [M-1:0] b_q;       // shifted left each step so the live bit is always the MSB
    logic [M-1:0] r_q;
    logic [M-1:0] r_next;
    logic [M-1:0] out_c_q;
    logic [M-1:0] acc_term;
    logic         accept;
    logic         out_hs;

`ifdef GF_MULT_ACC_EN
    logic         acc_flag_q;
    logic [M-1:0] acc_q;
    assign acc_term = acc_flag_q ? acc_q : '0;
`else
    assign acc_term = '0;
`endif

    gf_mult_step #(.M(M), .POLY(POLY)) u_step (
        .r      (r_q),
        .a      (a_q),
        .b_bit  (b_q[M-1]),
        .r_next (r_next)
    );

    // in_ready looks only at state and out_ready, so a result can be drained
    // and new operands loaded on the same edge.
    always_comb begin
        bus.in_ready = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
        accept       = bus.in_valid && bus.in_ready;
        out_hs       = (state == ST_DONE) && bus.out_ready;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_BUSY;
            ST_BUSY: if (cnt == 4'd0) state_nxt = ST_DONE;
            ST_DONE: begin
                if (accept)             state_nxt = ST_BUSY;
                else if (bus.out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            out_c_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q <= bus.in_a;
                b_q <= bus.in_b;
                r_q <= '0;
                cnt <= 4'(M - 1);
            end else if (state == ST_BUSY) begin
                r_q <= r_next;
                b_q <= b_q << 1;
                cnt <= cnt - 4'd1;
                if (cnt == 4'd0) begin
                    out_c_q <= r_next ^ acc_term;
                end
            end
        end
    end

`ifdef GF_MULT_ACC_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_flag_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            if (accept) acc_flag_q <= bus.in_acc;
            if (out_hs) acc_q      <= out_c_q;
        end
    end
`endif

    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_c     = out_c_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_gf_mult_seq.sv
// tb_gf_mult_seq: self-checking bench for gf_mult_seq (M=4/'h13 scoreboarded,
// M=8/'h11D directed). Honours GF_MULT_ACC_EN when defined.
module tb_gf_mult_seq;
    import gf_pkg::*;

    localparam int          M     = 4;
    localparam logic [16:0] POLY  = 17'h13;
    localparam int          M8    = 8;
    localparam logic [16:0] POLY8 = 17'h11D;
`ifdef GF_MULT_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic rst8;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    gf_mult_seq_if #(.M(M))  bus  ();
    gf_mult_seq_if #(.M(M8)) bus8 ();
    gf_state_t st4;
    gf_state_t st8;

    gf_mult_seq #(.M(M), .POLY(POLY)) dut (
        .clk(clk), .rst(rst), .bus(bus), .state_dbg(st4)
    );
    gf_mult_seq #(.M(M8), .POLY(POLY8)) dut8 (
        .clk(clk), .rst(rst8), .bus(bus8), .state_dbg(st8)
    );

    // ---------------- counters / reference ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Schoolbook carry-less product followed by polynomial long division.
    function automatic int unsigned gf_ref(input int unsigned a, input int unsigned b,
                                           input int m, input int unsigned poly);
        int unsigned p = 0;
        for (int i = 0; i < m; i++)
            if (((b >> i) & 1) != 0) p ^= (a << i);
        for (int k = 2 * m - 2; k >= m; k--)
            if (((p >> k) & 1) != 0) p ^= (poly << (k - m));
        return p;
    endfunction

    // ---------------- scoreboard ----------------
    logic [M-1:0] exp_q[$];
    int           acc_cyc_q[$];
    logic [M-1:0] model_acc = '0;
    logic         prev_pending = 1'b0;
    logic         rand_bp = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    if (!prev_pending) begin
                        check("latency", cyc - acc_cyc_q[0], M);
                        void'(acc_cyc_q.pop_front());
                    end
                    check("out_c", bus.out_c, exp_q[0]);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            prev_pending = bus.out_valid && !bus.out_ready;
        end
    end

    // ---------------- driver tasks (called at posedge + #1) ----------------
    task automatic drive_op(input logic [M-1:0] a, input logic [M-1:0] b,
                            input logic acc, output int acc_cycle);
        logic [M-1:0] e;
        bit           ok = 1'b0;
        acc_cycle  = -1;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_acc   = acc;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
        end else begin
            e = M'(gf_ref(a, b, M, POLY)) ^ ((ACC_EN && acc) ? model_acc : '0);
            model_acc = e;
            exp_q.push_back(e);
            acc_cycle = cyc + 1;
            acc_cyc_q.push_back(acc_cycle);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        acc_cyc_q.delete();
        model_acc    = '0;
        prev_pending = 1'b0;
    endtask

    task automatic run8(input logic [M8-1:0] a, input logic [M8-1:0] b,
                        input logic [M8-1:0] e, input string name);
        int  start;
        bit  seen = 1'b0;
        bus8.in_valid = 1'b1;
        bus8.in_a     = a;
        bus8.in_b     = b;
        @(negedge clk);
        check({name, "_in_ready"}, bus8.in_ready, 1);
        @(posedge clk); #1;
        start = cyc;
        bus8.in_valid = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus8.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_seen"}, seen, 1);
        if (seen) begin
            check({name, "_latency"}, cyc - start, M8);
            check({name, "_value"}, bus8.out_c, e);
        end
        @(posedge clk); #1;
    endtask

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int ac;
        int prev_ac;
        rst = 1'b1;  rst8 = 1'b1;
        bus.in_valid = 1'b0;  bus.in_a = '0;  bus.in_b = '0;  bus.in_acc = 1'b0;
        bus.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0; bus8.in_acc = 1'b0;
        bus8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;  rst8 = 1'b0;

        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_c", bus.out_c, 0);
        check("rst_state", st4, ST_IDLE);
        @(posedge clk); #1;

        // directed products, consumer always ready
        bus.out_ready = 1'b1;
        drive_op(4'd9, 4'd4, 1'b0, ac);   wait_idle();
        drive_op(4'd14, 4'd9, 1'b1, ac);  wait_idle();
        drive_op(4'd15, 4'd7, 1'b0, ac);  wait_idle();

        // backpressure: result must hold while out_ready is low
        bus.out_ready = 1'b0;
        drive_op(4'd15, 4'd7, 1'b0, ac);
        for (int t = 0; t < 20 && !bus.out_valid; t++) @(negedge clk);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_idle();
        @(negedge clk);
        check("bp_single_handshake", bus.out_valid, 0);
        @(posedge clk); #1;

        // back-to-back: accept coincides with each result handshake
        prev_ac = -1;
        for (int i = 0; i < 6; i++) begin
            drive_op(M'($urandom_range(0, 15)), M'($urandom_range(0, 15)), 1'b0, ac);
            bus.in_valid = 1'b1;   // keep valid high between operations
            if (prev_ac >= 0) check("b2b_spacing", ac - prev_ac, M + 1);
            prev_ac = ac;
        end
        bus.in_valid = 1'b0;
        wait_idle();

        // reset in the middle of a computation
        drive_op(4'd14, 4'd9, 1'b0, ac);
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_state", st4, ST_IDLE);
        @(posedge clk); #1;
        drive_op(4'd9, 4'd4, 1'b0, ac);  wait_idle();

        // randomized operands, accumulate requests and consumer stalls
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive_op(M'($urandom_range(0, 15)), M'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), ac);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        rand_bp = 1'b0;
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        wait_idle();

        // M=8 instance
        run8(8'h02, 8'h80, 8'h1D, "m8_a");
        run8(8'h00, 8'hFF, 8'h00, "m8_zero");
        run8(8'h01, 8'hA5, 8'hA5, "m8_one");
        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run8(ra, rb, 8'(gf_ref(ra, rb, M8, POLY8)), "m8_rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gf_mult_seq.md
# gf_mult_seq

Parametrised, iterative GF(2^M) multiplier with a valid/ready handshake on both sides, for the SQUID decoder datapath (syndrome and error-value arithmetic). It generalises the fixed 4-bit combinational GFMULT to any field width M and any primitive polynomial, and computes one product bit per cycle (MSB-first Horner). An optional accumulate mode XORs the new product into the previously delivered result.

## Interface
- M, default 4: field width in bits; legal 2..16.
- POLY, default 'h13: primitive polynomial, M+1 bits, bit M set (x^4+x+1 for M=4).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- in_a  in  M  multiplicand.
- in_b  in  M  multiplier.
- in_acc  in  1  accumulate request; used only when GF_MULT_ACC_EN is defined, otherwise ignored.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_c  out  M  product, reduced mod POLY.

## Operation
- States: IDLE, BUSY, DONE. Reset: state=IDLE, in_ready=1, out_valid=0, out_c=0, accumulator=0, counter=0.
- Accept: in_valid && in_ready. Latches a, b, acc flag; r=0; cnt=M-1; state goes to BUSY.
- BUSY step i (cnt = M-1 down to 0): r = xtime(r) ^ (b[cnt] ? a : 0). xtime(r) = (r<<1), XORed with POLY[M-1:0] when r[M-1]=1. On cnt=0 the step completes and state goes to DONE; out_c = r_final ^ (acc flag ? accumulator : 0).
- DONE: out_valid=1; out_c held stable until out_ready=1.
- in_ready = (state==IDLE) || (state==DONE && out_ready). On a simultaneous out handshake and in accept, the new operands load and state goes straight to BUSY; out_valid drops the next cycle.
- DONE with out_ready=1 and no new input: state goes to IDLE.
- Accumulator: loads out_c on every out handshake. Reset clears it.
- Operand zero: no early exit. Latency is always M cycles.
- rst in any state: immediate return to reset values. The in-flight operation is discarded.
- in_a/in_b changes while BUSY: no effect; operands are latched.
- Elaboration error if M is outside 2..16 or POLY[M]!=1.

## Timing
- Accept on edge E0. out_valid rises on edge E0+M, so M cycles of compute.
- Back-to-back throughput: one result per M+1 cycles when out_ready is held high.
- in_ready is combinational from state and out_ready. There is no combinational path from in_valid to any output.
- out_c and out_valid are registered.

## Configuration
- GF_MULT_ACC_EN defined: the accumulator register exists. in_acc=1 at accept yields out_c = a*b ^ (last delivered out_c).
- GF_MULT_ACC_EN undefined: no accumulator register. in_acc is ignored and out_c = a*b always.

## Structure
- Shared package gf_pkg:
  - default M and POLY constants.
  - state enum type (IDLE/BUSY/DONE).
  - xtime function.
- Sub-module gf_mult_step: combinational single Horner step with inputs r, a, bit and output r_next, parametrised on M and POLY.
- Top contains the FSM, counter, operand registers and accumulator.

## Test plan
- M=4, POLY='h13, out_ready=1: (9,4) -> 2; (14,9) -> 7; (15,7) -> 11. Each out_valid appears exactly 4 cycles after accept.
- Backpressure: hold out_ready=0 for 10 cycles after (15,7) -> out_c=11 stays stable, in_ready=0. Release -> one handshake only.
- Back-to-back with in_valid and out_ready always high -> accept coincides with each result handshake; results arrive at 5-cycle spacing.
- rst pulsed mid-BUSY on (14,9) -> next cycle out_valid=0 and in_ready=1. The following (9,4) yields 2.
- GF_MULT_ACC_EN: (9,4, acc=0) -> 2, then (14,9, acc=1) -> 2^7=5. Without the macro the same sequence gives 2, 7.
- M=8, POLY='h11D: (0x02,0x80) -> 0x1D; (0x00,0xFF) -> 0x00 after 8 cycles; (0x01,0xA5) -> 0xA5.
